fft_input_pair_feeder: RTL
==========================

Name: fft_input_pair_feeder

Overview:
- Upstream stage of the FFT butterfly datapath.
- Collects a serial stream of real, signed samples into N-point frames using ping-pong banks.
- Issues the first-stage operand pairs x[k], x[k+N/2] to the butterfly plus/minus units, one pair per cycle.
- Each output word is packed {real[15:0], imag[15:0]} with imag = 0, ready to drive the butterfly X and Y inputs directly.

Parameters:
- DW, 16, input sample width in bits; legal range 8..16; sign-extended to 16 bits on output.
- N, 16, points per frame; power of 2, 4..64; pairs per frame = N/2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- in_valid  input  1  sample present on in_data
- in_data  input  DW  signed sample
- in_ready  output  1  feeder can accept a sample this cycle
- out_ready  input  1  downstream butterfly stage accepts the pair this cycle
- out_valid  output  1  out_x/out_y hold a valid pair
- out_x  output  32  {x[k] sign-extended to 16 bits, 16'h0000}
- out_y  output  32  {x[k+N/2] sign-extended to 16 bits, 16'h0000}
- out_idx  output  log2(N/2)  pair index k
- out_last  output  1  high with the pair k = N/2-1
- frame_cnt  output  8  completed frames, wraps 255 -> 0

Behaviour:
- Reset (rst = 0, asynchronous):
  - out_valid, out_x, out_y, out_idx, out_last and frame_cnt go to 0; in_ready = 1 after release.
  - Both banks are marked EMPTY; write pointer = bank 0, slot 0; read pointer = bank 0, pair 0.
  - Partial frames are discarded. Bank contents need not be cleared.
- Bank states: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
  - Writes go to wr_bank only; pairs are read from rd_bank only.
- Input side:
  - in_ready = (state of wr_bank is EMPTY or FILLING).
  - A sample is accepted when in_valid && in_ready. It is stored at wr_slot, and wr_slot then increments.
  - When slot N-1 is accepted, wr_bank becomes FULL, wr_bank toggles and wr_slot returns to 0.
  - When in_valid = 0 the pointer holds; gaps in the input stream are legal.
- Output side:
  - A bank that is FULL and equals rd_bank becomes DRAINING on the next edge. The registered pair (k = 0) appears with out_valid = 1.
  - Latency: the first pair is valid on the 2nd rising edge after the edge that accepted sample N-1.
  - A pair transfers on out_valid && out_ready; the next pair loads on the same edge.
  - While out_valid && !out_ready, out_x/out_y/out_idx/out_last hold stable. No pair is ever dropped or duplicated.
- Frame completion:
  - On transfer of pair N/2-1: rd_bank is set EMPTY, rd_bank toggles, frame_cnt increments.
  - If the other bank is already FULL, its pair 0 loads on that same edge, so there is no bubble between frames.
- Throughput: with out_ready held at 1, one frame drains in N/2 cycles, which is less than the N fill cycles. Input therefore never stalls at 1 sample/cycle.
- Both banks FULL or DRAINING: in_ready = 0. in_valid is ignored and must be held by the source.
- A bank released on the same edge that the other bank starts FILLING is legal. The release takes effect for in_ready in the next cycle.
- Arithmetic: in_data is sign-extended DW -> 16 bits. There is no rounding or saturation in base mode.

Optional Feature:
- Macro: FFT_FEEDER_PRESCALE_EN.
- Defined: each accepted sample is stored as its 16-bit sign-extended value arithmetically shifted right by 1 (floor), e.g. -3 -> -2, 5 -> 2. This gives one bit of headroom against the non-growing butterfly adders.
- Undefined: samples are stored unscaled. Behaviour is otherwise identical, including latency.

Test Plan:
- Reset: hold rst = 0 for 3 cycles with in_valid = 1 -> out_valid = 0, frame_cnt = 0 and in_ready = 1 after release; no pair is emitted.
- Single frame, ramp 1..16, out_ready = 1 -> 8 pairs. First pair: out_x = 0x0001_0000, out_y = 0x0009_0000, idx 0. Last pair: 0x0008_0000 / 0x0010_0000 with out_last = 1 and idx 7. frame_cnt = 1.
- Backpressure: out_ready = 0 for 5 cycles at k = 3 -> outputs frozen at 0x0004_0000 / 0x000C_0000 and k = 3 for all 5 cycles. Resumes at k = 4 with no loss.
- Bank exhaustion: out_ready = 0 while 32 samples are sent -> in_ready drops after sample 32, the 33rd sample is held. Raising out_ready drains 16 pairs back to back with no bubble at the frame boundary.
- Signed data, DW = 12: sample 0x800 (-2048) -> real field 0xF800. With FFT_FEEDER_PRESCALE_EN: samples -3 and 5 -> 0xFFFE and 0x0002.
- Reset mid-frame after 10 samples -> partial frame discarded. The next 16 samples form frame 0 and frame_cnt ends at 1.

Source files
------------

// File: rtl/fft_input_pair_feeder.sv
// Ping-pong frame buffer feeding first-stage FFT butterfly pairs x[k], x[k+N/2].
// Ports: clk, rst (async, active-low), in_valid/in_data/in_ready sample input,
// out_ready/out_valid/out_x/out_y/out_idx/out_last pair output, frame_cnt.
// Option: FFT_FEEDER_PRESCALE_EN stores each sample arithmetically halved.
module fft_input_pair_feeder #(
  parameter int DW = 16,
  parameter int N  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DW-1:0]          in_data,
  output logic                   in_ready,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [31:0]            out_x,
  output logic [31:0]            out_y,
  output logic [$clog2(N/2)-1:0] out_idx,
  output logic                   out_last,
  output logic [7:0]             frame_cnt
);

  localparam int SW   = $clog2(N);
  localparam int PW   = $clog2(N/2);
  localparam int HALF = N / 2;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_t;

  bank_t st   [2];
  bank_t st_n [2];

  logic [15:0]   mem [2][N];
  logic          wr_bank;
  logic          rd_bank;
  logic          other;
  logic [SW-1:0] wr_slot;
  logic [PW-1:0] rd_pair;
  logic [PW-1:0] ld_pair;
  logic          ld_bank;

  logic signed [15:0] ext;
  logic [15:0]        wdata;

  logic accept;
  logic wr_end;
  logic xfer;
  logic done;
  logic first;
  logic chain;
  logic load;

  assign ext = 16'($signed(in_data));

`ifdef FFT_FEEDER_PRESCALE_EN
  assign wdata = ext >>> 1;
`else
  assign wdata = ext;
`endif

  assign in_ready = (st[wr_bank] == EMPTY) ||
                    (st[wr_bank] == FILLING);

  assign accept = in_valid && in_ready;
  assign wr_end = accept && (wr_slot == SW'(N-1));
  assign xfer   = out_valid && out_ready;
  assign done   = xfer && out_last;
  assign other  = ~rd_bank;

  // first: bank just went DRAINING with nothing held yet.
  // chain: other bank already full, so start it without a bubble.
  assign first   = !out_valid && (st[rd_bank] == DRAINING);
  assign chain   = done && (st[other] == FULL);
  assign load    = first || (xfer && !out_last) || chain;
  assign ld_bank = chain ? other : rd_bank;
  assign ld_pair = chain ? '0 : rd_pair;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      st_n[b] = st[b];
      if (accept && (wr_bank == 1'(b))) begin
        st_n[b] = wr_end ? FULL : FILLING;
      end
      if (done) begin
        if (rd_bank == 1'(b)) begin
          st_n[b] = EMPTY;
        end else if (st[b] == FULL) begin
          st_n[b] = DRAINING;
        end
      end else if (!out_valid && (rd_bank == 1'(b))
                   && (st[b] == FULL)) begin
        st_n[b] = DRAINING;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_bank][wr_slot] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st[0]     <= EMPTY;
      st[1]     <= EMPTY;
      wr_bank   <= 1'b0;
      wr_slot   <= '0;
      rd_bank   <= 1'b0;
      rd_pair   <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      st[0] <= st_n[0];
      st[1] <= st_n[1];
      if (accept) begin
        wr_slot <= wr_end ? '0 : wr_slot + SW'(1);
        if (wr_end) begin
          wr_bank <= ~wr_bank;
        end
      end
      if (done) begin
        rd_bank   <= other;
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_x     <= {mem[ld_bank][{1'b0, ld_pair}], 16'h0000};
        out_y     <= {mem[ld_bank][{1'b1, ld_pair}], 16'h0000};
        out_idx   <= ld_pair;
        out_last  <= (ld_pair == PW'(HALF-1));
        rd_pair   <= ld_pair + PW'(1);
      end else if (done) begin
        out_valid <= 1'b0;
        rd_pair   <= '0;
      end
    end
  end

endmodule
